// File: rtl/seq_div.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned per operation,
// with start/done handshake, registered quotient/remainder and divide-by-zero flag.
module seq_div #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 busy,
  output logic                 done,
  output logic                 dbz
);
  localparam int CW  = $clog2(DATAWIDTH + 1);
  localparam int MSB = DATAWIDTH - 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, nstate;

  // qd holds the dividend bits still to be consumed at the top and the
  // quotient bits produced so far at the bottom.
  logic [DATAWIDTH-1:0] qd, dsr, prem;
  logic [CW-1:0]        cnt;
  logic                 qneg, rneg, zdiv;
  logic [DATAWIDTH-1:0] amag, bmag;
  logic [DATAWIDTH:0]   shft, diff;
  logic                 bzero;

  always_comb begin
    bzero = (b == '0);
    amag  = (sgn && a[MSB]) ? -a : a;
    bmag  = (sgn && b[MSB]) ? -b : b;
    shft  = {prem, qd[MSB]};
    diff  = shft - {1'b0, dsr};
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    busy   = (state != IDLE);
    case (state)
      IDLE: if (start) nstate = bzero ? FIN : CALC;
      CALC: if (cnt == CW'(DATAWIDTH - 1)) nstate = FIN;
      FIN:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      quot <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
      done <= 1'b0;
      qd   <= '0;
      dsr  <= '0;
      prem <= '0;
      cnt  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      zdiv <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // Divide-by-zero preloads the final answer so FIN needs no special case.
          qd   <= bzero ? '1 : amag;
          prem <= bzero ? a  : '0;
          dsr  <= bmag;
          cnt  <= '0;
          qneg <= ~bzero & sgn & (a[MSB] ^ b[MSB]);
          rneg <= ~bzero & sgn & a[MSB];
          zdiv <= bzero;
        end
        CALC: begin
          prem <= diff[DATAWIDTH] ? shft[DATAWIDTH-1:0] : diff[DATAWIDTH-1:0];
          qd   <= {qd[DATAWIDTH-2:0], ~diff[DATAWIDTH]};
          cnt  <= cnt + CW'(1);
        end
        FIN: begin
          quot <= qneg ? -qd : qd;
          rem  <= rneg ? -prem : prem;
          dbz  <= zdiv;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (DATAWIDTH=8).
module tb_seq_div;
  logic       Clk = 1'b0;
  logic       Rst, start, sgn;
  logic [7:0] a, b, quot, rem;
  logic       busy, done, dbz;

  int errors = 0;
  int checks = 0;

  seq_div #(.DATAWIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .quot(quot), .rem(rem), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 Clk = ~Clk;

  // Drives one request at the current negedge and waits for done.
  // edges = rising edges from accept to the edge that raised done.
  task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                        output int edges, output int bcyc);
    int n;
    start = 1'b1; sgn = s; a = x; b = y;
    n = 0; bcyc = 0;
    do begin
      @(negedge Clk);
      start = 1'b0;
      n++;
      if (busy) bcyc++;
    end while (!done && n < 40);
    edges = n - 1;
  endtask

  task automatic test_reset;
    Rst = 1'b1; start = 1'b1; sgn = 1'b0; a = 8'd100; b = 8'd7;
    repeat (2) @(negedge Clk);
    checks++;
    if ({busy, done, dbz, quot, rem} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b quot=%h rem=%h, want all 0", busy, done, dbz, quot, rem);
    end
    Rst = 1'b0; start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_unsigned;
    int e, bc;
    run_op(1'b0, 8'h64, 8'h07, e, bc);
    checks++; if (e !== 9) begin errors++; $display("FAIL unsigned_latency: got %0d want 9", e); end
    checks++; if (bc !== 9) begin errors++; $display("FAIL unsigned_busy_cycles: got %0d want 9", bc); end
    checks++; if ({quot, rem, dbz} !== {8'h0E, 8'h02, 1'b0}) begin
      errors++; $display("FAIL unsigned_100_7: quot=%h rem=%h dbz=%b want 0e 02 0", quot, rem, dbz); end
    @(negedge Clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || quot !== 8'h0E) begin
      errors++; $display("FAIL done_pulse_hold: done=%b busy=%b quot=%h want 0 0 0e", done, busy, quot); end
  endtask

  task automatic test_signed;
    int e, bc;
    run_op(1'b1, 8'h9C, 8'h07, e, bc);
    checks++; if ({quot, rem} !== {8'hF2, 8'hFE}) begin
      errors++; $display("FAIL signed_m100_7: quot=%h rem=%h want f2 fe", quot, rem); end
    run_op(1'b1, 8'h64, 8'hF9, e, bc);
    checks++; if ({quot, rem} !== {8'hF2, 8'h02}) begin
      errors++; $display("FAIL signed_100_m7: quot=%h rem=%h want f2 02", quot, rem); end
    run_op(1'b1, 8'h9C, 8'hF9, e, bc);
    checks++; if ({quot, rem} !== {8'h0E, 8'hFE}) begin
      errors++; $display("FAIL signed_m100_m7: quot=%h rem=%h want 0e fe", quot, rem); end
  endtask

  task automatic test_overflow;
    int e, bc;
    run_op(1'b1, 8'h80, 8'hFF, e, bc);
    checks++; if ({quot, rem, dbz} !== {8'h80, 8'h00, 1'b0}) begin
      errors++; $display("FAIL signed_overflow: quot=%h rem=%h dbz=%b want 80 00 0", quot, rem, dbz); end
    run_op(1'b0, 8'h80, 8'hFF, e, bc);
    checks++; if ({quot, rem} !== {8'h00, 8'h80}) begin
      errors++; $display("FAIL unsigned_80_ff: quot=%h rem=%h want 00 80", quot, rem); end
    run_op(1'b0, 8'hFF, 8'h01, e, bc);
    checks++; if ({quot, rem} !== {8'hFF, 8'h00}) begin
      errors++; $display("FAIL unsigned_ff_1: quot=%h rem=%h want ff 00", quot, rem); end
  endtask

  task automatic test_div_zero;
    int e, bc;
    run_op(1'b0, 8'h2A, 8'h00, e, bc);
    checks++; if (e !== 1) begin errors++; $display("FAIL dbz_latency_u: got %0d want 1", e); end
    checks++; if ({quot, rem, dbz} !== {8'hFF, 8'h2A, 1'b1}) begin
      errors++; $display("FAIL dbz_unsigned: quot=%h rem=%h dbz=%b want ff 2a 1", quot, rem, dbz); end
    run_op(1'b1, 8'hD6, 8'h00, e, bc);
    checks++; if (e !== 1) begin errors++; $display("FAIL dbz_latency_s: got %0d want 1", e); end
    checks++; if ({quot, rem, dbz} !== {8'hFF, 8'hD6, 1'b1}) begin
      errors++; $display("FAIL dbz_signed: quot=%h rem=%h dbz=%b want ff d6 1", quot, rem, dbz); end
    run_op(1'b0, 8'h10, 8'h04, e, bc);
    checks++; if ({quot, rem, dbz} !== {8'h04, 8'h00, 1'b0}) begin
      errors++; $display("FAIL after_dbz: quot=%h rem=%h dbz=%b want 04 00 0", quot, rem, dbz); end
  endtask

  task automatic test_back_to_back;
    int n, e, bc;
    start = 1'b1; sgn = 1'b0; a = 8'd200; b = 8'd3;
    @(negedge Clk); start = 1'b0;
    repeat (3) @(negedge Clk);
    start = 1'b1; a = 8'd9; b = 8'd9;
    @(negedge Clk); start = 1'b0; a = 8'h55; b = 8'h11;
    n = 5;
    while (!done && n < 40) begin @(negedge Clk); n++; end
    checks++; if (n - 1 !== 9) begin errors++; $display("FAIL busy_ignore_latency: got %0d want 9", n - 1); end
    checks++; if ({quot, rem} !== {8'h42, 8'h02}) begin
      errors++; $display("FAIL busy_ignore: quot=%h rem=%h want 42 02", quot, rem); end
    run_op(1'b0, 8'd9, 8'd9, e, bc);
    checks++; if (e !== 9) begin errors++; $display("FAIL b2b_latency: got %0d want 9", e); end
    checks++; if ({quot, rem} !== {8'h01, 8'h00}) begin
      errors++; $display("FAIL b2b_result: quot=%h rem=%h want 01 00", quot, rem); end
  endtask

  task automatic test_reset_mid;
    int seen, e, bc;
    start = 1'b1; sgn = 1'b0; a = 8'd200; b = 8'd3;
    @(negedge Clk); start = 1'b0;
    repeat (4) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0;
    checks++; if ({busy, done, quot, rem} !== 18'd0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b quot=%h rem=%h want 0 0 00 00", busy, done, quot, rem); end
    seen = 0;
    repeat (15) begin @(negedge Clk); if (done || busy) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_abort: %0d busy/done cycles, want 0", seen); end
    run_op(1'b0, 8'd50, 8'd5, e, bc);
    checks++; if ({quot, rem} !== {8'h0A, 8'h00}) begin
      errors++; $display("FAIL after_reset: quot=%h rem=%h want 0a 00", quot, rem); end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    @(negedge Clk);
    test_reset;
    test_unsigned;
    test_signed;
    test_overflow;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle radix-2 restoring divider with a start/done handshake and registered quotient and remainder.
- Successor to the combinational DIV datapath component.
- Generalised in DATAWIDTH; adds a per-operation signed/unsigned mode, a remainder output and divide-by-zero detection.
- Used in scheduled datapaths where a single-cycle divider fails timing.

Parameters:
- DATAWIDTH, 8, operand/result width in bits; legal range 2 to 64.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where busy=0.
- sgn  input  1  sampled at accept; 1 = two's-complement signed, 0 = unsigned.
- a  input  DATAWIDTH  dividend, sampled at accept.
- b  input  DATAWIDTH  divisor, sampled at accept.
- quot  output  DATAWIDTH  registered quotient; holds until the next done.
- rem  output  DATAWIDTH  registered remainder; holds until the next done.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; quot/rem/dbz are valid from this cycle.
- dbz  output  1  divide-by-zero flag for the last completed operation; holds until the next done.

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE; quot=0, rem=0, busy=0, done=0, dbz=0. Reset overrides start. Reset mid-operation aborts the operation and produces no done.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, iteration counter 0..DATAWIDTH-1.
  - FIN: busy=1, sign fix-up cycle.
- done is a registered pulse issued on the edge that leaves CALC/FIN back to IDLE.
- Accept: edge with start=1 and busy=0 (state IDLE, including the done cycle).
  - a, b and sgn are captured.
  - In signed mode, |a| and |b| are formed and the quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]) are stored.
  - Next state is CALC with counter=0.
  - If b==0, next state is FIN directly (divide-by-zero fast path).
- CALC: each edge shifts the partial remainder left by one and brings in the next dividend MSB. Trial subtract of |b|: if non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0. The counter increments. After DATAWIDTH iterations the next state is FIN.
- FIN, one edge:
  - Apply the sign fix-up: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Load quot/rem/dbz, pulse done, return to IDLE.
- Latency:
  - Normal: done is high in the cycle after edge E0+DATAWIDTH+1, where E0 is the accept edge (9 edges after accept for DATAWIDTH=8).
  - Divide-by-zero: done after edge E0+1.
- Divide by zero, both modes: quot=all ones, rem=a (unmodified), dbz=1.
- Signed overflow (a = most-negative, b = -1): quot=most-negative, rem=0, dbz=0. The natural result of the magnitude algorithm plus truncating negation gives this; no special case is needed beyond DATAWIDTH-bit wrap.
- Signed results:
  - Quotient truncates toward zero.
  - Remainder carries the dividend's sign; |rem| < |b|.
  - a = quot*b + rem holds modulo 2^DATAWIDTH.
- Internal widths: partial remainder DATAWIDTH+1 bits; counter $clog2(DATAWIDTH+1) bits.
- start while busy=1: ignored. No queuing, and in-flight operands are unaffected.
- start in the done cycle: accepted. Back-to-back operations need no idle gap.
- Operand inputs are not required to be stable after the accept edge.
- quot/rem/dbz change only on a done edge or on reset.

Test Plan:
1. Unsigned: sgn=0, a=100 (0x64), b=7 -> done 9 edges after accept, quot=0x0E, rem=0x02, dbz=0. busy high for exactly 9 cycles.
2. Signed: sgn=1, a=0x9C (-100), b=0x07 -> quot=0xF2 (-14), rem=0xFE (-2). Then a=0x64, b=0xF9 (-7) -> quot=0xF2, rem=0x02.
3. Overflow and unsigned extreme: sgn=1, a=0x80, b=0xFF -> quot=0x80, rem=0x00, dbz=0. sgn=0, same operands -> quot=0x00, rem=0x80.
4. Divide by zero: a=0x2A, b=0x00 (both sgn values) -> done 1 edge after accept, quot=0xFF, rem=0x2A, dbz=1. Next normal op 0x10/0x04 -> quot=0x04, rem=0x00, dbz=0.
5. Handshake:
   - Start 200/3, pulse start with 9/9 at edge 4 while busy -> result 0x42 r 0x02; the second request is ignored.
   - Start 9/9 during the done cycle -> accepted; quot=0x01 after 9 more edges.
6. Reset mid-operation: start 200/3, assert Rst at edge 5 -> next cycle busy=0, done=0, quot=0, rem=0. No done pulse appears afterwards; a subsequent 50/5 returns quot=0x0A, rem=0.
